// File: rtl/fir_inverse_filter.sv
// fir_inverse_filter: all-pole deconvolver y(n) = x(n) - sum w(k)*y(n-k), one MAC per cycle.
// Rev 1.0
`default_nettype none

module fir_inverse_filter #(
  parameter int TAPS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC       = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      x_N,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAPS*DATA_WIDTH-1:0] w_N,
  input  logic                       hist_clr,
  output logic [DATA_WIDTH-1:0]      y_N,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int ACC_W = 2*DATA_WIDTH + $clog2(TAPS) + 1;
  localparam int K_W   = $clog2(TAPS);
  localparam int NH    = TAPS - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_RND, S_OUT} state_t;

  state_t                        state_q, state_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [K_W-1:0]                k_q, k_d;
  logic signed [DATA_WIDTH-1:0]  y_q, y_d;
  logic                          out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0]  hist_q [NH];
  logic signed [DATA_WIDTH-1:0]  hist_d [NH];
  // Indexed directly by k; slot 0 holds the ignored unity tap and is never multiplied.
  logic signed [DATA_WIDTH-1:0]  wreg_q [TAPS];
  logic signed [DATA_WIDTH-1:0]  wreg_d [TAPS];

  logic [K_W-1:0]                hist_idx;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]       shifted;

  assign hist_idx  = k_q - K_W'(1);
  assign prod      = wreg_q[k_q] * hist_q[hist_idx];
  assign shifted   = acc_q >>> FRAC;
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign y_N       = y_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    k_d         = k_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    hist_d      = hist_q;
    wreg_d      = wreg_q;
    case (state_q)
      S_IDLE: begin
        // Clear lands on the same edge as the accept, so the MAC pass sees zeros.
        if (hist_clr) begin
          for (int i = 0; i < NH; i++) hist_d[i] = '0;
        end
        if (in_valid) begin
          for (int i = 0; i < TAPS; i++) wreg_d[i] = w_N[i*DATA_WIDTH +: DATA_WIDTH];
          acc_d   = {{(ACC_W-DATA_WIDTH){x_N[DATA_WIDTH-1]}}, x_N} <<< FRAC;
          k_d     = K_W'(1);
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q - ACC_W'(prod);
        k_d   = k_q + K_W'(1);
        if (k_q == K_W'(TAPS-1)) state_d = S_RND;
      end
      S_RND: begin
        if (shifted > SAT_MAX)      y_d = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN) y_d = SAT_MIN[DATA_WIDTH-1:0];
        else                        y_d = shifted[DATA_WIDTH-1:0];
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          hist_d[0] = y_q;
          for (int i = 1; i < NH; i++) hist_d[i] = hist_q[i-1];
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NH; i++)   hist_q[i] <= '0;
      for (int i = 0; i < TAPS; i++) wreg_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < NH; i++)   hist_q[i] <= hist_d[i];
      for (int i = 0; i < TAPS; i++) wreg_q[i] <= wreg_d[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_inverse_filter.sv
// Bench for fir_inverse_filter: directed test-plan cases plus random samples against an arithmetic model.
`default_nettype none

module tb_fir_inverse_filter;

  localparam int TAPS = 4;
  localparam int DW   = 16;
  localparam int FRAC = 14;

  logic               clk = 1'b0;
  logic               rst;
  logic [DW-1:0]      x_N;
  logic               in_valid;
  logic               in_ready;
  logic [TAPS*DW-1:0] w_N;
  logic               hist_clr;
  logic [DW-1:0]      y_N;
  logic               out_valid;
  logic               out_ready;

  int     checks = 0;
  int     errors = 0;
  longint mh [TAPS-1];

  always #5 clk = ~clk;

  fir_inverse_filter #(.TAPS(TAPS), .DATA_WIDTH(DW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .x_N(x_N), .in_valid(in_valid), .in_ready(in_ready),
    .w_N(w_N), .hist_clr(hist_clr), .y_N(y_N), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < TAPS-1; i++) mh[i] = 0;
  endfunction

  // y = clamp(floor((x*2^FRAC - sum w(k)*y(n-k)) / 2^FRAC))
  function automatic longint model_y(input longint x, input logic [TAPS*DW-1:0] w);
    longint acc = x * 64'sd16384;
    longint y;
    for (int k = 1; k < TAPS; k++) acc -= longint'($signed(w[k*DW +: DW])) * mh[k-1];
    y = acc >>> FRAC;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  function automatic logic [TAPS*DW-1:0] w_one(input int c);
    logic [TAPS*DW-1:0] w = '0;
    w[DW-1:0]  = 16'h7ABC;  // unity slot carries garbage; must be ignored
    w[DW +: DW] = DW'(c);
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; hist_clr = 1'b0; out_ready = 1'b0;
    tick();
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_y", longint'($signed(y_N)), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", longint'(in_ready), 1);
    model_clear();
  endtask

  task automatic accept(input longint x, input logic [TAPS*DW-1:0] w, input logic clr,
                        output longint exp_y);
    int n;
    chk("idle_in_ready", longint'(in_ready), 1);
    if (clr) model_clear();
    exp_y = model_y(x, w);
    x_N = DW'(x); w_N = w; in_valid = 1'b1; hist_clr = clr;
    tick();
    in_valid = 1'b0; hist_clr = 1'b0;
    x_N = DW'($urandom); w_N = {$urandom, $urandom};
    chk("busy_in_ready", longint'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", longint'(n), TAPS);
    chk("y", longint'($signed(y_N)), exp_y);
  endtask

  task automatic handshake(input longint exp_y);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid", longint'(out_valid), 0);
    chk("hs_in_ready", longint'(in_ready), 1);
    for (int i = TAPS-2; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = exp_y;
  endtask

  task automatic sample(input longint x, input logic [TAPS*DW-1:0] w, input logic clr,
                        output longint got);
    longint e;
    accept(x, w, clr, e);
    got = longint'($signed(y_N));
    handshake(e);
  endtask

  initial begin
    longint got, e, ysave;
    logic [TAPS*DW-1:0] w;
    rst = 1'b1; x_N = '0; in_valid = 1'b0; w_N = '0; hist_clr = 1'b0; out_ready = 1'b0;
    tick();
    do_reset();

    // Passthrough
    sample(100, w_one(0), 1'b0, got);  chk("pass_100", got, 100);
    sample(-5, w_one(0), 1'b0, got);   chk("pass_m5", got, -5);

    // Impulse response from clean history
    do_reset();
    sample(16384, w_one(8192), 1'b0, got); chk("imp0", got, 16384);
    sample(0, w_one(8192), 1'b0, got);     chk("imp1", got, -8192);
    sample(0, w_one(8192), 1'b0, got);     chk("imp2", got, 4096);
    sample(0, w_one(8192), 1'b0, got);     chk("imp3", got, -2048);

    // Saturation: clamped value feeds history
    do_reset();
    sample(30000, w_one(-16384), 1'b0, got); chk("sat0", got, 30000);
    sample(30000, w_one(-16384), 1'b0, got); chk("sat1", got, 32767);
    sample(-1, w_one(-16384), 1'b0, got);    chk("sat2", got, 32766);

    // Backpressure with toggling inputs
    accept(1234, w_one(4096), 1'b0, e);
    ysave = longint'($signed(y_N));
    repeat (10) begin
      in_valid = 1'($urandom); hist_clr = 1'($urandom);
      x_N = DW'($urandom); w_N = {$urandom, $urandom};
      tick();
      chk("bp_y", longint'($signed(y_N)), ysave);
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_in_ready", longint'(in_ready), 0);
    end
    in_valid = 1'b0; hist_clr = 1'b0;
    handshake(e);
    sample(-700, w_one(8192), 1'b0, got);

    // Reset in the middle of a MAC pass
    x_N = DW'(16'sd9999); w_N = w_one(8192); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midmac_out_valid", longint'(out_valid), 0);
    #1;
    chk("midmac_in_ready", longint'(in_ready), 1);
    repeat (6) tick();
    chk("midmac_quiet", longint'(out_valid), 0);
    model_clear();
    sample(16384, w_one(8192), 1'b0, got); chk("rimp0", got, 16384);
    sample(0, w_one(8192), 1'b0, got);     chk("rimp1", got, -8192);

    // hist_clr together with an accept
    sample(100, w_one(8192), 1'b1, got);   chk("clr_100", got, 100);

    // FIR round-trip
    sample(1000, w_one(8192), 1'b1, got);  chk("rt0", got, 1000);
    sample(-1500, w_one(8192), 1'b0, got); chk("rt1", got, -2000);
    sample(2000, w_one(8192), 1'b0, got);  chk("rt2", got, 3000);
    sample(1500, w_one(8192), 1'b0, got);  chk("rt3", got, 0);

    // Random samples, random coefficients, random output stall
    for (int s = 0; s < 40; s++) begin
      w = '0;
      for (int k = 1; k < TAPS; k++) w[k*DW +: DW] = DW'(int'($urandom_range(0, 32767)) - 16384);
      accept(longint'(int'($urandom_range(0, 65535)) - 32768), w, 1'(($urandom % 8) == 0), e);
      ysave = longint'($signed(y_N));
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("rnd_hold", longint'($signed(y_N)), ysave);
      end
      handshake(e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
